fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, the byte address loaded into the PC on reset.
REQ-002 SHALL provide parameter MEM_DEPTH, default 256, the number of 32-bit words in instruction memory.
REQ-003 SHALL provide parameter HALT_WORD, default 32'hFC000000, the instruction encoding that halts fetch.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port imem_addr  output  32  word index to instruction memory, combinational {2'b00, pc[31:2]}.
REQ-007 SHALL have port instruction  input  32  word returned by instruction memory for imem_addr, same cycle.
REQ-008 SHALL have port stall  input  1  hold PC and fetch register.
REQ-009 SHALL have port flush  input  1  invalidate the word captured this cycle.
REQ-010 SHALL have port branch_taken  input  1  take conditional branch.
REQ-011 SHALL have port branch_offset  input  32  sign-extended word offset.
REQ-012 SHALL have port jump  input  1  take absolute jump.
REQ-013 SHALL have port jump_target  input  26  jump word-address field.
REQ-014 SHALL have ports if_instr 32, if_pc_plus4 32, if_valid 1 (all outputs): registered fetch result.
REQ-015 SHALL have ports pc 32, halted 1, fault 1, fetch_count 32 (all outputs): status.

Function
REQ-016 SHALL hold a state machine with states RUN, HALT, FAULT; HALT and FAULT are exited only by reset.
REQ-017 SHALL compute pc_plus4 = pc + 4, modulo 2^32.
REQ-018 SHALL compute branch target = pc_plus4 + (branch_offset << 2), modulo 2^32.
REQ-019 SHALL compute jump target = {pc_plus4[31:28], jump_target, 2'b00}.
REQ-020 SHALL apply this next-PC priority in RUN with stall=0: jump > branch_taken > pc_plus4.
REQ-021 SHALL, in RUN with stall=0 at the clock edge, load pc with next-PC, if_instr with instruction, if_pc_plus4 with pc_plus4, if_valid with !flush, and increment fetch_count by 1 (wraps at 2^32).
REQ-022 SHALL, in RUN with stall=1, hold pc, if_instr, if_pc_plus4 and fetch_count; if_valid holds unless flush=1, which clears it.
REQ-023 SHALL go to FAULT when pc[31:2] >= MEM_DEPTH or pc[1:0] != 0 in RUN; FAULT is checked before HALT and regardless of stall.
REQ-024 SHALL go to HALT when instruction == HALT_WORD in RUN with stall=0; on that edge pc holds, if_valid <= 0, and fetch_count still increments.
REQ-025 SHALL, in HALT or FAULT, hold pc and fetch_count, force if_valid=0, and ignore stall, flush, branch_taken and jump.
REQ-026 SHALL drive halted=1 only in HALT and fault=1 only in FAULT, both decoded from state.
REQ-027 SHALL give one-cycle latency from imem_addr presentation to if_instr/if_valid.
REQ-028 SHALL drive pc as the current PC register value.

Reset
REQ-029 SHALL, on a rising clk edge with reset_n=0, set pc=RESET_PC, state=RUN, if_instr=0, if_pc_plus4=0, if_valid=0, fetch_count=0, halted=0, fault=0.
REQ-030 SHALL give reset priority over every other input, including mid-stall, HALT and FAULT.
REQ-031 SHALL keep imem_addr valid (= RESET_PC>>2) during reset.

Verification
REQ-032 SHALL cover sequential fetch: reset, 3 cycles with no control -> pc 0,4,8,C; if_pc_plus4 4,8,C; fetch_count 3; if_valid=1.
REQ-033 SHALL cover redirect: pc=8, branch_offset=-2 -> pc=4 next; pc=8 with jump_target=26'h10 and branch_taken=1 -> pc=32'h40, since jump wins.
REQ-034 SHALL cover stall/flush: stall=1 for 2 cycles at pc=C -> pc and if_instr held; stall=1 with flush=1 -> if_valid=0 and pc still C.
REQ-035 SHALL cover halt: instruction=32'hFC000000 at pc=10 -> next cycle halted=1, if_valid=0, pc=10, with a jump input ignored thereafter.
REQ-036 SHALL cover fault: jump to word 256 (pc=32'h400) -> fault=1 next cycle, pc frozen at 32'h400.
REQ-037 SHALL cover reset mid-HALT: reset_n=0 for one edge -> pc=0, halted=0, fetch_count=0, if_valid=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC select, fetch register.
// Ports: clk/reset_n; imem_addr/instruction memory link;
//   stall/flush/branch/jump control; if_* fetch result; pc/halted/
//   fault/fetch_count status.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;
    logic        pc_bad;

    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = pc_plus4 + (branch_offset << 2);
    assign jmp_target = {pc_plus4[31:28], jump_target, 2'b00};
    assign pc_bad     = ({2'b00, pc_q[31:2]} >= DEPTH)
                        || (pc_q[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jmp_target;
        end else if (branch_taken) begin
            next_pc = br_target;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
        unique case (state_q)
            RUN: begin
                // Bad PC wins over everything, even a stalled cycle.
                if (pc_bad) begin
                    state_d    = FAULT;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (instruction == HALT_WORD) begin
                        state_d    = HALT;
                        if_valid_d = 1'b0;
                    end else begin
                        pc_d          = next_pc;
                        if_instr_d    = instruction;
                        if_pc_plus4_d = pc_plus4;
                        if_valid_d    = !flush;
                    end
                end else if (flush) begin
                    if_valid_d = 1'b0;
                end
            end
            HALT, FAULT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d    = FAULT;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_instr_q    <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Present the reset vector while reset is held so memory is never
    // addressed from an unknown PC.
    assign imem_addr   = reset_n ? {2'b00, pc_q[31:2]}
                                 : {2'b00, RESET_PC[31:2]};
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_valid    = if_valid_q;
    assign pc          = pc_q;
    assign fetch_count = fetch_count_q;
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver queues expected state per
// step, monitor compares after each rising edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic [31:0] pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_addr    (imem_addr),
        .instruction  (instruction),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .if_instr     (if_instr),
        .if_pc_plus4  (if_pc_plus4),
        .if_valid     (if_valid),
        .pc           (pc),
        .halted       (halted),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign instruction = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 32'h0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        v;
        logic [31:0] cnt;
        logic        h;
        logic        f;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] W0  = 32'h1000_0000;
    localparam logic [31:0] W1  = 32'h1000_0001;
    localparam logic [31:0] W2  = 32'h1000_0002;
    localparam logic [31:0] W3  = 32'h1000_0003;
    localparam logic [31:0] W16 = 32'h1000_0010;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            logic ok;
            e = sb.pop_front();
            ok = (pc == e.pc) && (if_valid == e.v)
                 && (fetch_count == e.cnt) && (halted == e.h)
                 && (fault == e.f) && (imem_addr == {2'b00, e.pc[31:2]});
            if (e.chk_data) begin
                ok = ok && (if_instr == e.ins) && (if_pc_plus4 == e.p4);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got pc=%h ins=%h p4=%h v=%b cnt=%0d h=%b f=%b ia=%h want pc=%h ins=%h p4=%h v=%b cnt=%0d h=%b f=%b",
                         e.name, pc, if_instr, if_pc_plus4, if_valid,
                         fetch_count, halted, fault, imem_addr,
                         e.pc, e.ins, e.p4, e.v, e.cnt, e.h, e.f);
            end
        end
    end

    task automatic step(
        input string       nm,
        input logic        rst_n, stl, fl, br,
        input logic [31:0] off,
        input logic        jp,
        input logic [25:0] jt,
        input logic [31:0] epc, eins, ep4,
        input logic        ev,
        input logic [31:0] ecnt,
        input logic        eh, ef, ecd
    );
        exp_t e;
        @(negedge clk);
        reset_n       = rst_n;
        stall         = stl;
        flush         = fl;
        branch_taken  = br;
        branch_offset = off;
        jump          = jp;
        jump_target   = jt;
        e.name = nm; e.pc = epc; e.ins = eins; e.p4 = ep4; e.v = ev;
        e.cnt = ecnt; e.h = eh; e.f = ef; e.chk_data = ecd;
        sb.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[4] = 32'hFC00_0000;
        reset_n = 1'b0; stall = 0; flush = 0; branch_taken = 0;
        branch_offset = 0; jump = 0; jump_target = 0;

        //    name        rst stl fl br off           jp jt      pc          ins  p4          v cnt h f d
        step("reset",     0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h0,  32'h0, 32'h0,  0, 0, 0, 0, 1);
        step("seq0",      1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h4,  W0, 32'h4,  1, 1, 0, 0, 1);
        step("seq1",      1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h8,  W1, 32'h8,  1, 2, 0, 0, 1);
        step("seq2",      1, 0, 0, 0, 32'h0,        0, 26'h0,  32'hC,  W2, 32'hC,  1, 3, 0, 0, 1);
        step("stall1",    1, 1, 0, 0, 32'h0,        0, 26'h0,  32'hC,  W2, 32'hC,  1, 3, 0, 0, 1);
        step("stall2",    1, 1, 0, 1, 32'h5,        1, 26'h7,  32'hC,  W2, 32'hC,  1, 3, 0, 0, 1);
        step("stallflush",1, 1, 1, 0, 32'h0,        0, 26'h0,  32'hC,  W2, 32'hC,  0, 3, 0, 0, 1);
        step("jump8",     1, 0, 0, 0, 32'h0,        1, 26'h2,  32'h8,  W3, 32'h10, 1, 4, 0, 0, 1);
        step("branchm2",  1, 0, 0, 1, 32'hFFFFFFFE, 0, 26'h0,  32'h4,  W2, 32'hC,  1, 5, 0, 0, 1);
        step("seq4",      1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h8,  W1, 32'h8,  1, 6, 0, 0, 1);
        step("jumpwins",  1, 0, 0, 1, 32'h5,        1, 26'h10, 32'h40, W2, 32'hC,  1, 7, 0, 0, 1);
        step("jump10",    1, 0, 0, 0, 32'h0,        1, 26'h4,  32'h10, W16,32'h44, 1, 8, 0, 0, 1);
        step("halt",      1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h10, 32'h0, 32'h0, 0, 9, 1, 0, 0);
        step("haltjump",  1, 0, 0, 0, 32'h0,        1, 26'h2,  32'h10, 32'h0, 32'h0, 0, 9, 1, 0, 0);
        step("haltctl",   1, 1, 1, 1, 32'h3,        0, 26'h0,  32'h10, 32'h0, 32'h0, 0, 9, 1, 0, 0);
        step("rsthalt",   0, 0, 0, 0, 32'h0,        1, 26'h5,  32'h0,  32'h0, 32'h0, 0, 0, 0, 0, 1);
        step("jump400",   1, 0, 0, 0, 32'h0,        1, 26'h100,32'h400,W0, 32'h4,  1, 1, 0, 0, 1);
        step("fault",     1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h400,32'h0, 32'h0, 0, 1, 0, 1, 0);
        step("faultstl",  1, 1, 0, 0, 32'h0,        0, 26'h0,  32'h400,32'h0, 32'h0, 0, 1, 0, 1, 0);
        step("faultjmp",  1, 0, 0, 1, 32'h1,        1, 26'h1,  32'h400,32'h0, 32'h0, 0, 1, 0, 1, 0);
        step("rstfault",  0, 0, 0, 0, 32'h0,        0, 26'h0,  32'h0,  32'h0, 32'h0, 0, 0, 0, 0, 1);
        step("seqA",      1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h4,  W0, 32'h4,  1, 1, 0, 0, 1);
        step("seqB",      1, 0, 0, 0, 32'h0,        0, 26'h0,  32'h8,  W1, 32'h8,  1, 2, 0, 0, 1);
        step("rststall",  0, 1, 0, 0, 32'h0,        0, 26'h0,  32'h0,  32'h0, 32'h0, 0, 0, 0, 0, 1);
        step("seqC",      1, 0, 1, 0, 32'h0,        0, 26'h0,  32'h4,  W0, 32'h4,  0, 1, 0, 0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
